playback_sequencer: RTL and testbench

Top-level playback controller for the MP3 player. Turns raw button levels (play/pause, previous, next, mode) and the decoder's end-of-song pulse into a selected song index, a playing flag and a load request/acknowledge handshake toward the SD-reader/decoder chain. Its index-selection logic supersedes the standalone button-driven song selector. Auto-advance follows a play mode: sequential, repeat-one or repeat-all.

---
 rtl/playback_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_playback_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/playback_sequencer.sv
// Playback controller: turns button edges and decoder end-of-song pulses into a song index,
// a playing flag, a play mode and a load request/acknowledge handshake toward the reader.
module playback_sequencer #(
    parameter int NUM_SONGS = 4,
    parameter int IDX_W     = 3,
    parameter int LOCKOUT   = 10000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             btn_play,
    input  logic             btn_pre,
    input  logic             btn_nxt,
    input  logic             btn_mode,
    input  logic             song_end,
    input  logic             load_ack,
    output logic [IDX_W-1:0] current,
    output logic [IDX_W-1:0] load_idx,
    output logic             load_req,
    output logic             playing,
    output logic [1:0]       mode
);

    localparam int CNT_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SONGS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [1:0] MODE_SEQ = 2'd0;
    localparam logic [1:0] MODE_ONE = 2'd1;
    localparam logic [1:0] MODE_ALL = 2'd2;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_PLAY  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    function automatic logic [IDX_W-1:0] step_up(input logic [IDX_W-1:0] idx, input logic wrap);
        if (idx == LAST_IDX) begin
            step_up = wrap ? IDX_ZERO : idx;
        end else begin
            step_up = idx + IDX_W'(1);
        end
    endfunction

    function automatic logic [IDX_W-1:0] step_dn(input logic [IDX_W-1:0] idx, input logic wrap);
        if (idx == IDX_ZERO) begin
            step_dn = wrap ? LAST_IDX : idx;
        end else begin
            step_dn = idx - IDX_W'(1);
        end
    endfunction

    function automatic logic [1:0] mode_next(input logic [1:0] m);
        case (m)
            MODE_SEQ: mode_next = MODE_ONE;
            MODE_ONE: mode_next = MODE_ALL;
            default:  mode_next = MODE_SEQ;
        endcase
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       hist_r;
    logic             armed_r;
    logic [IDX_W-1:0] current_r;
    logic [IDX_W-1:0] load_idx_r;
    logic             load_req_r;
    logic             playing_r;
    logic [1:0]       mode_r;

    logic [3:0]       press_s;
    logic             end_s;
    logic             open_s;
    logic             do_play_s, do_pre_s, do_nxt_s, do_mode_s, take_s;
    logic             wrap_s;
    logic [IDX_W-1:0] up_s, dn_s;

    // End of song in PLAY outranks any press on the same edge, so it also blocks the lockout.
    always_comb begin
        press_s   = {btn_mode, btn_nxt, btn_pre, btn_play} & ~hist_r;
        end_s     = song_end && (state_r == ST_PLAY);
        open_s    = (cnt_r == CNT_ZERO) && (state_r != ST_LOAD) && !end_s;
        do_play_s = open_s && press_s[0];
        do_pre_s  = open_s && press_s[1] && !press_s[0];
        do_nxt_s  = open_s && press_s[2] && (press_s[1:0] == 2'b00);
        do_mode_s = open_s && press_s[3] && (press_s[2:0] == 3'b000);
        take_s    = open_s && (press_s != 4'b0000);
        wrap_s    = (mode_r == MODE_ALL);
        up_s      = step_up(current_r, wrap_s);
        dn_s      = step_dn(current_r, wrap_s);
    end

    // Sequencer FSM with button history, lockout counter and all registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_STOP;
            cnt_r      <= CNT_ZERO;
            hist_r     <= 4'b0000;
            armed_r    <= 1'b0;
            current_r  <= IDX_ZERO;
            load_idx_r <= IDX_ZERO;
            load_req_r <= 1'b0;
            playing_r  <= 1'b0;
            mode_r     <= MODE_SEQ;
        end else begin
            hist_r <= {btn_mode, btn_nxt, btn_pre, btn_play};
            if (take_s) begin
                cnt_r <= CNT_LOAD;
            end else if (cnt_r != CNT_ZERO) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (do_mode_s) begin
                mode_r <= mode_next(mode_r);
            end else begin
                mode_r <= mode_r;
            end
            case (state_r)
                ST_STOP: begin
                    if (do_play_s) begin
                        state_r    <= ST_LOAD;
                        load_req_r <= 1'b1;
                        load_idx_r <= current_r;
                        playing_r  <= 1'b0;
                        armed_r    <= 1'b0;
                    end else if (do_pre_s) begin
                        current_r <= dn_s;
                    end else if (do_nxt_s) begin
                        current_r <= up_s;
                    end else begin
                        current_r <= current_r;
                    end
                end
                ST_LOAD: begin
                    // The entry cycle only arms the acknowledge; it is honoured from the next edge.
                    if (armed_r && load_ack) begin
                        state_r    <= ST_PLAY;
                        load_req_r <= 1'b0;
                        playing_r  <= 1'b1;
                    end else begin
                        armed_r <= 1'b1;
                    end
                end
                ST_PLAY, ST_PAUSE: begin
                    if (end_s) begin
                        if ((mode_r == MODE_SEQ) && (current_r == LAST_IDX)) begin
                            state_r   <= ST_STOP;
                            playing_r <= 1'b0;
                        end else begin
                            state_r    <= ST_LOAD;
                            load_req_r <= 1'b1;
                            load_idx_r <= (mode_r == MODE_ONE) ? current_r : up_s;
                            current_r  <= (mode_r == MODE_ONE) ? current_r : up_s;
                            playing_r  <= 1'b0;
                            armed_r    <= 1'b0;
                        end
                    end else if (do_play_s) begin
                        state_r   <= (state_r == ST_PLAY) ? ST_PAUSE : ST_PLAY;
                        playing_r <= (state_r != ST_PLAY);
                    end else if (do_pre_s || do_nxt_s) begin
                        state_r    <= ST_LOAD;
                        load_req_r <= 1'b1;
                        load_idx_r <= do_pre_s ? dn_s : up_s;
                        current_r  <= do_pre_s ? dn_s : up_s;
                        playing_r  <= 1'b0;
                        armed_r    <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r    <= ST_STOP;
                    load_req_r <= 1'b0;
                    playing_r  <= 1'b0;
                end
            endcase
        end
    end

    assign current  = current_r;
    assign load_idx = load_idx_r;
    assign load_req = load_req_r;
    assign playing  = playing_r;
    assign mode     = mode_r;

endmodule

// File: tb/tb_playback_sequencer.sv
// Bench for playback_sequencer: directed button/decoder stimulus, an abstract behavioural
// model compared every cycle, plus hand-computed literal expectations.
module tb_playback_sequencer;

    localparam int NUM_SONGS = 4;
    localparam int IDX_W     = 3;
    localparam int LOCKOUT   = 4;
    localparam int S_STOP = 0, S_LOAD = 1, S_PLAY = 2, S_PAUSE = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic btn_play = 1'b0, btn_pre = 1'b0, btn_nxt = 1'b0, btn_mode = 1'b0;
    logic song_end = 1'b0, load_ack = 1'b0;
    logic [IDX_W-1:0] current, load_idx;
    logic load_req, playing;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;
    bit model_live = 1'b0;

    int m_cur = 0, m_idx = 0, m_mode = 0, m_st = S_STOP, m_lock = 0, m_age = 0;
    bit m_req = 1'b0, m_play = 1'b0;
    bit [3:0] m_hist = 4'b0000;

    playback_sequencer #(.NUM_SONGS(NUM_SONGS), .IDX_W(IDX_W), .LOCKOUT(LOCKOUT)) dut (
        .CLK(CLK), .RST(RST),
        .btn_play(btn_play), .btn_pre(btn_pre), .btn_nxt(btn_nxt), .btn_mode(btn_mode),
        .song_end(song_end), .load_ack(load_ack),
        .current(current), .load_idx(load_idx), .load_req(load_req),
        .playing(playing), .mode(mode)
    );

    always #5 CLK = ~CLK;

    function automatic int step(int cur, int dir, int md);
        int n = cur + dir;
        if (md == 2) return (n + NUM_SONGS) % NUM_SONGS;
        if (n < 0) return 0;
        if (n > NUM_SONGS - 1) return NUM_SONGS - 1;
        return n;
    endfunction

    task automatic go_load();
        m_st = S_LOAD; m_req = 1'b1; m_idx = m_cur; m_play = 1'b0; m_age = 0;
    endtask

    // Behavioural model: advanced once per rising edge from the same inputs the DUT sees.
    always @(posedge CLK) begin : model
        bit [3:0] b;
        bit [3:0] pr;
        int which;
        if (RST) begin
            m_cur = 0; m_idx = 0; m_req = 1'b0; m_play = 1'b0; m_mode = 0;
            m_st = S_STOP; m_lock = 0; m_hist = 4'b0000; m_age = 0;
            model_live = 1'b1;
        end else begin
            b = {btn_mode, btn_nxt, btn_pre, btn_play};
            pr = b & ~m_hist;
            m_hist = b;
            which = -1;
            if (m_lock == 0 && m_st != S_LOAD && !(m_st == S_PLAY && song_end))
                for (int i = 3; i >= 0; i--) if (pr[i]) which = i;
            if (which >= 0) m_lock = LOCKOUT - 1;
            else if (m_lock > 0) m_lock--;
            if (m_st == S_LOAD) begin
                m_age++;
                if (m_age >= 2 && load_ack) begin
                    m_st = S_PLAY; m_req = 1'b0; m_play = 1'b1;
                end
            end else if (m_st == S_PLAY && song_end) begin
                if (m_mode == 0 && m_cur == NUM_SONGS - 1) begin
                    m_st = S_STOP; m_play = 1'b0;
                end else begin
                    if (m_mode != 1) m_cur = step(m_cur, 1, m_mode);
                    go_load();
                end
            end else begin
                case (which)
                    0: begin
                        if (m_st == S_STOP) go_load();
                        else if (m_st == S_PLAY) begin m_st = S_PAUSE; m_play = 1'b0; end
                        else begin m_st = S_PLAY; m_play = 1'b1; end
                    end
                    1, 2: begin
                        m_cur = step(m_cur, (which == 1) ? -1 : 1, m_mode);
                        if (m_st != S_STOP) go_load();
                    end
                    3: m_mode = (m_mode + 1) % 3;
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (model_live) begin
            chk("model.current", int'(current), m_cur);
            chk("model.load_idx", int'(load_idx), m_idx);
            chk("model.load_req", int'(load_req), int'(m_req));
            chk("model.playing", int'(playing), int'(m_play));
            chk("model.mode", int'(mode), m_mode);
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic set_btn(int b, logic v);
        case (b)
            0: btn_play = v;
            1: btn_pre  = v;
            2: btn_nxt  = v;
            default: btn_mode = v;
        endcase
    endtask

    task automatic press(int b);
        set_btn(b, 1'b1);
        cyc(1);
        set_btn(b, 1'b0);
        cyc(5);
    endtask

    task automatic ack();
        cyc(2);
        load_ack = 1'b1;
        cyc(1);
        load_ack = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_end();
        song_end = 1'b1;
        cyc(1);
        song_end = 1'b0;
    endtask

    initial begin
        // 1: reset, play, delayed acknowledge
        cyc(2);
        RST = 1'b0;
        chk("rst.current", int'(current), 0);
        chk("rst.load_req", int'(load_req), 0);
        chk("rst.playing", int'(playing), 0);
        chk("rst.mode", int'(mode), 0);
        btn_play = 1'b1;
        cyc(1);
        btn_play = 1'b0;
        chk("t1.load_req", int'(load_req), 1);
        chk("t1.load_idx", int'(load_idx), 0);
        cyc(2);
        load_ack = 1'b1;
        cyc(1);
        load_ack = 1'b0;
        chk("t1.playing", int'(playing), 1);
        chk("t1.req_drop", int'(load_req), 0);
        cyc(3);

        // 2: sequential end at last song, then repeat-all wrap
        repeat (3) begin press(2); ack(); end
        chk("t2.cur3", int'(current), 3);
        pulse_end();
        chk("t2.stop_playing", int'(playing), 0);
        chk("t2.stop_cur", int'(current), 3);
        chk("t2.stop_req", int'(load_req), 0);
        press(3); press(3);
        chk("t2.mode_all", int'(mode), 2);
        press(0); ack();
        pulse_end();
        chk("t2.wrap_cur", int'(current), 0);
        chk("t2.wrap_req", int'(load_req), 1);
        ack();
        press(1);
        chk("t2.pre_wrap", int'(current), 3);
        chk("t2.pre_wrap_idx", int'(load_idx), 3);
        ack();
        press(3);
        chk("t2.mode_seq", int'(mode), 0);

        // 5: saturating restart, pause/resume, minimum LOAD time
        press(2);
        chk("t5.restart_req", int'(load_req), 1);
        chk("t5.restart_idx", int'(load_idx), 3);
        ack();
        press(1); ack();
        press(0);
        chk("t5.pause_playing", int'(playing), 0);
        press(0);
        chk("t5.resume_playing", int'(playing), 1);
        chk("t5.resume_noreq", int'(load_req), 0);
        press(0);
        load_ack = 1'b1;
        btn_nxt = 1'b1;
        cyc(1);
        btn_nxt = 1'b0;
        chk("t5.nxt_idx", int'(load_idx), 3);
        cyc(1);
        chk("t5.min_load", int'(load_req), 1);
        cyc(1);
        chk("t5.ack_playing", int'(playing), 1);
        load_ack = 1'b0;
        cyc(4);

        // 3: stop, saturate at 0, long hold fires once
        pulse_end();
        cyc(4);
        press(1); press(1); press(1);
        press(1);
        chk("t3.sat0", int'(current), 0);
        btn_nxt = 1'b1;
        cyc(20);
        btn_nxt = 1'b0;
        cyc(2);
        chk("t3.hold_once", int'(current), 1);

        // 4: lockout and simultaneous priority
        btn_pre = 1'b1;
        cyc(1);
        btn_pre = 1'b0;
        btn_nxt = 1'b1;
        cyc(1);
        btn_nxt = 1'b0;
        cyc(5);
        chk("t4.lockout", int'(current), 0);
        press(2);
        btn_pre = 1'b1;
        btn_nxt = 1'b1;
        cyc(1);
        btn_pre = 1'b0;
        btn_nxt = 1'b0;
        chk("t4.pre_wins", int'(current), 0);
        cyc(5);

        // 6: reset during a load, later ack ignored
        press(2); press(2); press(3); press(0);
        chk("t6.req", int'(load_req), 1);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        chk("t6.req0", int'(load_req), 0);
        chk("t6.cur0", int'(current), 0);
        chk("t6.mode0", int'(mode), 0);
        chk("t6.play0", int'(playing), 0);
        load_ack = 1'b1;
        cyc(1);
        load_ack = 1'b0;
        cyc(3);
        chk("t6.late_ack_req", int'(load_req), 0);
        chk("t6.late_ack_play", int'(playing), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
